stream_serializer: RTL and testbench
====================================

// Module: stream_serializer
// PURPOSE
//   Width-down converter placed directly downstream of the FIFO. It takes one
//   IN_WIDTH word from the FIFO output handshake and emits it as OUT_WIDTH
//   chunks, least-significant chunk first, on a valid/ready stream.
//   A per-word chunk count allows short words to be sent.
//   OUT_last marks the final chunk of each word.
// PARAMETERS
//   IN_WIDTH   32  input word width; must be an integer multiple of OUT_WIDTH
//   OUT_WIDTH   8  output chunk width
//   RATIO      IN_WIDTH/OUT_WIDTH (localparam, must be >= 2)
//   CW         $clog2(RATIO) (localparam), width of the count field
// PORTS
//   clk        in   1          single clock; all state updates on posedge clk
//   rst        in   1          reset, asynchronous, active-low
//   IN_data    in   IN_WIDTH   word from the FIFO (FIFO OUT_data)
//   IN_count   in   CW         chunks in word minus 1 (0 => 1 chunk)
//   IN_valid   in   1          word valid (FIFO OUT_valid)
//   OUT_ready  out  1          word accepted this cycle if high (to FIFO IN_ready)
//   OUT_data   out  OUT_WIDTH  current chunk
//   OUT_valid  out  1          chunk valid
//   OUT_last   out  1          current chunk is the word's final chunk
//   IN_ready   in   1          downstream consumer accepts the chunk
// BEHAVIOUR
//   - Reset (rst=0, async): state IDLE; OUT_valid=0, OUT_last=0, OUT_data=0.
//     The shift buffer, idx and last_idx are set to 0.
//     A word in progress is discarded and no remaining chunks are emitted.
//   - States:
//     - IDLE: no word held.
//     - BUSY: a word is held in buf, with idx = chunk index and last_idx.
//   - OUT_valid = (state==BUSY). OUT_data = buf[OUT_WIDTH-1:0].
//     OUT_last = BUSY && idx==last_idx. All three are registered.
//   - OUT_ready = IDLE || (OUT_valid && IN_ready && OUT_last).
//     This path is combinational from IN_ready and gives zero-bubble handover.
//   - Word accept (IN_valid && OUT_ready):
//     - Load buf with IN_data, idx=0, last_idx=min(IN_count, RATIO-1).
//     - State goes to BUSY.
//     - The first chunk appears on the next cycle (latency 1).
//   - Chunk accept (OUT_valid && IN_ready) on a non-last chunk:
//     - buf shifts right by OUT_WIDTH with zero fill; idx increments.
//   - Chunk accept on the last chunk:
//     - If a word is accepted in the same cycle, load it (stay BUSY).
//     - Otherwise go to IDLE.
//   - While OUT_valid && !IN_ready: OUT_data, OUT_last and buf hold stable.
//   - IN_data and IN_count are sampled only on a word accept; other values are ignored.
//   - IN_count > RATIO-1 (only possible when RATIO is not a power of 2) is clamped.
//   - Sustained throughput is 1 chunk/cycle, i.e. (IN_count+1) cycles per word.
//   - OUT_valid never drops before its chunk is accepted; there is no
//     combinational path from IN_valid to OUT_valid.
//   - Clearing rst returns the block to IDLE.
//     OUT_ready then reads 1 whenever the block is in IDLE, including during reset.
// TESTING (IN_WIDTH=32, OUT_WIDTH=8)
//   1. Word 0xDDCCBBAA, count=3, IN_ready=1 -> AA,BB,CC,DD on cycles 1-4.
//      OUT_last is high only with DD; OUT_ready is high on cycles 0 and 4.
//   2. Two words with IN_valid held and IN_ready=1 -> 8 consecutive valid
//      beats with no gap; OUT_last is high on beats 4 and 8.
//   3. Word 0x00003412, count=1 -> 12 then 34 (OUT_last=1); IDLE next cycle.
//   4. Backpressure: IN_ready=0 for 3 cycles after AA is taken -> OUT_data
//      holds BB with OUT_valid=1; the sequence resumes with no loss or duplicate.
//   5. rst asserted while CC is pending -> OUT_valid and OUT_data read 0
//      immediately; after release, the next word starts cleanly at chunk 0.
//   6. Chained after FIFO(NUM=4, WIDTH=32), push 4 words, random IN_ready ->
//      16 chunks in order with exactly 4 OUT_last pulses.

Source files
------------

// File: rtl/stream_serializer.sv
// stream_serializer: splits one IN_WIDTH word into OUT_WIDTH chunks, LS chunk first.
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active low
//   IN_data    word from the FIFO
//   IN_count   chunks in word minus one, clamped to RATIO-1
//   IN_valid   word valid
//   OUT_ready  word taken this cycle when high (combinational from IN_ready)
//   OUT_data   current chunk
//   OUT_valid  chunk valid
//   OUT_last   current chunk is the final chunk of its word
//   IN_ready   downstream accepts the chunk
module stream_serializer #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
   localparam int CW       = $clog2(RATIO)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  IN_data,
   input  logic [CW-1:0]        IN_count,
   input  logic                 IN_valid,
   output logic                 OUT_ready,
   output logic [OUT_WIDTH-1:0] OUT_data,
   output logic                 OUT_valid,
   output logic                 OUT_last,
   input  logic                 IN_ready
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [CW-1:0] MAX_IDX = CW'(RATIO - 1);
   state_t              state_q;
   logic [IN_WIDTH-1:0] buf_q;
   logic [CW-1:0]       idx_q;
   logic [CW-1:0]       last_idx_q;
   logic [CW-1:0]       last_idx_d;
   logic                last_q;
   logic                word_acc;
   logic                chunk_acc;
   // Clamping is only reachable when RATIO is not a power of two.
   if ((RATIO & (RATIO - 1)) == 0) begin : g_pow2
      assign last_idx_d = IN_count;
   end else begin : g_clamp
      assign last_idx_d = (IN_count > MAX_IDX) ? MAX_IDX : IN_count;
   end
   assign OUT_valid = (state_q == BUSY);
   assign OUT_data  = buf_q[OUT_WIDTH-1:0];
   assign OUT_last  = last_q;
   assign chunk_acc = OUT_valid && IN_ready;
   // Taking the next word while the last chunk leaves gives zero-bubble handover.
   assign OUT_ready = (state_q == IDLE) || (chunk_acc && last_q);
   assign word_acc  = IN_valid && OUT_ready;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         idx_q      <= '0;
         last_idx_q <= '0;
         last_q     <= 1'b0;
      end else if (word_acc) begin
         state_q    <= BUSY;
         buf_q      <= IN_data;
         idx_q      <= '0;
         last_idx_q <= last_idx_d;
         last_q     <= (last_idx_d == '0);
      end else if (chunk_acc) begin
         if (last_q) begin
            state_q <= IDLE;
            buf_q   <= '0;
            last_q  <= 1'b0;
         end else begin
            buf_q  <= buf_q >> OUT_WIDTH;
            idx_q  <= idx_q + 1'b1;
            last_q <= (CW'(idx_q + 1'b1) == last_idx_q);
         end
      end
   end
endmodule

// File: tb/tb_stream_serializer.sv
// tb_stream_serializer: directed and random checks of stream_serializer against a chunk-queue model.
module tb_stream_serializer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] IN_data = '0;
   logic [1:0]  IN_count = '0;
   logic        IN_valid = 1'b0;
   logic        IN_ready = 1'b0;
   logic        OUT_ready;
   logic [7:0]  OUT_data;
   logic        OUT_valid;
   logic        OUT_last;

   typedef struct packed {logic [7:0] d; logic l;} beat_t;
   beat_t       exp_q[$];
   logic [31:0] src_w[$];
   logic [1:0]  src_c[$];
   int          errors = 0;
   int          checks = 0;
   int          rdy_mode = 0;
   bit          gaps = 0;
   int          lasts = 0;
   int          beats = 0;

   stream_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .IN_data(IN_data), .IN_count(IN_count),
      .IN_valid(IN_valid), .OUT_ready(OUT_ready), .OUT_data(OUT_data),
      .OUT_valid(OUT_valid), .OUT_last(OUT_last), .IN_ready(IN_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input logic [31:0] w, input logic [1:0] c);
      src_w.push_back(w);
      src_c.push_back(c);
   endtask

   // One clock: drive inputs after the falling edge, check, then apply the model at the rising edge.
   task automatic tick();
      logic  exp_ready, take, acc;
      beat_t b;
      int    n;
      IN_valid = (src_w.size() != 0) && (!gaps || $urandom_range(0, 3) != 0);
      IN_data  = IN_valid ? src_w[0] : $urandom;
      IN_count = IN_valid ? src_c[0] : 2'($urandom);
      IN_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && IN_ready);
      chk("out_ready", OUT_ready, exp_ready);
      chk("out_valid", OUT_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         chk("out_data", OUT_data, exp_q[0].d);
         chk("out_last", OUT_last, exp_q[0].l);
      end
      @(posedge clk);
      take = (exp_q.size() != 0) && IN_ready;
      acc  = IN_valid && exp_ready;
      if (take) begin
         b = exp_q.pop_front();
         beats++;
         if (b.l) lasts++;
      end
      if (acc) begin
         n = int'(src_c[0]) + 1;
         for (int k = 0; k < n; k++) begin
            b.d = 8'((src_w[0] >> (8 * k)) & 32'hFF);
            b.l = (k == n - 1);
            exp_q.push_back(b);
         end
         void'(src_w.pop_front());
         void'(src_c.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drain(input string tag, input int budget);
      int left = budget;
      while ((exp_q.size() != 0 || src_w.size() != 0) && left > 0) begin
         tick();
         left--;
      end
      chk(tag, exp_q.size() + src_w.size(), 0);
   endtask

   initial begin
      int l0, b0;
      #1;
      chk("rst_valid", OUT_valid, 0);
      chk("rst_last", OUT_last, 0);
      chk("rst_data", OUT_data, 0);
      chk("rst_ready", OUT_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      // 1: full word, ready always high; accept on cycle 0, beats on cycles 1-4
      rdy_mode = 0;
      push(32'hDDCCBBAA, 2'd3);
      run(5);
      chk("t1_idle", OUT_valid, 0);
      chk("t1_lasts", lasts, 1);
      // 2: two words back to back, no gap expected
      push(32'h44332211, 2'd3);
      push(32'h88776655, 2'd3);
      l0 = lasts;
      run(9);
      chk("t2_beats_done", exp_q.size() + src_w.size(), 0);
      chk("t2_lasts", lasts - l0, 2);
      // 3: short word of two chunks
      push(32'h00003412, 2'd1);
      run(3);
      chk("t3_idle", OUT_valid, 0);
      // 4: backpressure after first chunk is taken
      push(32'hDDCCBBAA, 2'd3);
      run(2);
      rdy_mode = 2;
      run(3);
      chk("t4_hold_data", OUT_data, 8'hBB);
      rdy_mode = 0;
      run(3);
      chk("t4_idle", OUT_valid, 0);
      // 5: reset while CC pending
      push(32'hDDCCBBAA, 2'd3);
      run(3);
      chk("t5_pending_cc", OUT_data, 8'hCC);
      #2 rst = 1'b0;
      #1;
      chk("t5_rst_valid", OUT_valid, 0);
      chk("t5_rst_data", OUT_data, 0);
      chk("t5_rst_ready", OUT_ready, 1);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      push(32'h0A0B0C0D, 2'd3);
      drain("t5_drain", 20);
      // 6: four FIFO words with random downstream ready
      rdy_mode = 1;
      l0 = lasts;
      b0 = beats;
      for (int i = 0; i < 4; i++) push($urandom, 2'd3);
      drain("t6_drain", 200);
      chk("t6_beats", beats - b0, 16);
      chk("t6_lasts", lasts - l0, 4);
      // random counts, gaps on the source and random ready
      gaps = 1;
      l0 = lasts;
      for (int i = 0; i < 40; i++) push($urandom, 2'($urandom));
      drain("rand_drain", 2000);
      chk("rand_lasts", lasts - l0, 40);
      gaps = 0;
      rdy_mode = 0;
      run(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
